reg_file_2r1w: RTL
==================

# reg_file_2r1w

Parametrised register file with two read ports and one write port. It replaces the fixed 16-bit, 8-input read multiplexer of the datapath with a single block that holds the storage array and performs both read selections. Width, depth, hardwired-zero entry, write-to-read bypass and an optional registered read stage are all set by parameter. It sits between the decode stage (addresses) and the ALU operand inputs.

## Interface
- WIDTH, 16: data width of each entry.
- DEPTH, 8: number of entries; any value 2..256, not required to be a power of two.
- AW, $clog2(DEPTH): address width; derived, not overridden.
- ZERO_REG, 1: 1 makes entry 0 always read 0 and ignore writes; 0 makes entry 0 an ordinary register.
- BYPASS, 1: 1 forwards same-cycle write data to a matching read port; 0 returns pre-write contents.
- READ_REG, 0: 0 gives combinational read ports; 1 gives registered read ports with 1-cycle latency.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- WE  in  1  write enable.
- WA  in  AW  write address.
- WD  in  WIDTH  write data.
- RA0  in  AW  read address, port 0.
- RD0  out  WIDTH  read data, port 0.
- RA1  in  AW  read address, port 1.
- RD1  out  WIDTH  read data, port 1.

## Operation
- Storage is an array of DEPTH entries of WIDTH bits.
- **Write:** on a rising CLK edge with WE=1, entry WA is loaded with WD.
  - The write is ignored if WA ≥ DEPTH.
  - The write is ignored if ZERO_REG=1 and WA=0.
- **Read:** each port independently selects entry RA.
  - RA ≥ DEPTH returns 0.
  - RA=0 with ZERO_REG=1 returns 0.
  - Both ports may use the same address at the same time; each returns the same value.
- **Bypass (BYPASS=1):** when WE=1, WA=RA, and the write is legal (per the write rules above), the port returns WD instead of the stored value.
  - With READ_REG=0 this applies in the same cycle.
  - With READ_REG=1 it applies to the value captured at that edge.
- **Reset:** RST_N=0 clears every entry to 0 immediately, independent of CLK.
  - Reset dominates WE.
  - A write presented during reset, or on the edge at which reset is still low, is lost.
- **Registered read state machine (READ_REG=1):** per port, output register RDx_q.
  - Each rising edge loads RDx_q with the read result for the RA present before that edge, including bypass.
  - There is no enable and no hold state; the register updates every cycle.

## Timing
- **Write latency:** new data is visible in the array after the edge on which WE=1.
- **READ_REG=0:**
  - RD follows RA combinationally within the same cycle.
  - BYPASS=1: a write in cycle N is visible on RD in cycle N.
  - BYPASS=0: the write is visible in cycle N+1.
- **READ_REG=1:**
  - An address applied in cycle N appears on RD in cycle N+1.
  - BYPASS=1: a write to the same address in cycle N is returned in N+1.
  - BYPASS=0: the old value is returned in N+1 and the new value from N+2 onward.
- **Reset values:**
  - RD0 = RD1 = 0 while RST_N=0.
  - READ_REG=1: the output registers clear asynchronously.
  - READ_REG=0: the output is 0 because the array is 0; an out-of-range or zero-register address also gives 0.
- **Reset release:** deassertion of RST_N is not synchronised by this block. The first edge with RST_N=1 performs normal writes and reads.
- **Reset mid-operation:** the array and output registers go to 0 within the same cycle; no partial write occurs.

## Test plan
- **Defaults, sequential fill:**
  - Stimulus: after reset, write entry k with value k for k=1..7, then sweep RA0 through 0..7 at 20 ns steps.
  - Required: RD0 = 0,1,2,3,4,5,6,7.
  - Required: RD1 with RA1=7-k gives the mirror sequence.
- **Zero register:**
  - Stimulus: write WA=0, WD=16'hFFFF, then read RA0=0.
  - Required: RD0 = 0 with ZERO_REG=1; RD0 = 16'hFFFF with ZERO_REG=0.
- **Bypass:**
  - Stimulus: entry 3 = 16'h0003; in one cycle apply WE=1, WA=3, WD=16'hABCD, RA0=RA1=3.
  - BYPASS=1, READ_REG=0: RD0 = RD1 = 16'hABCD in that cycle.
  - BYPASS=0: 16'h0003 in that cycle, then 16'hABCD.
- **Registered read:**
  - Stimulus: READ_REG=1; RA0 steps 1→2→5 on successive edges.
  - Required: RD0 lags by one cycle, giving 1, 2, 5.
  - Required: bypass case from the previous scenario gives 16'hABCD one cycle later.
- **Reset mid-operation:**
  - Stimulus: fill entries with nonzero values, pull RST_N low between edges.
  - Required: RD0, RD1 and all entries read 0 immediately; a WE=1 presented during reset has no effect after release.
- **Non-power-of-two depth:**
  - Stimulus: DEPTH=6, AW=3; write WA=6, WD=16'h1234, then read RA0=6 and RA0=7.
  - Required: both reads return 0; entries 0..5 unchanged.

Source files
------------

// File: rtl/reg_file_2r1w.sv
// Two-read, one-write register file with optional zero entry,
// write-to-read bypass and registered read ports.
module reg_file_2r1w #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int READ_REG = 0,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             WE,
    input  logic [AW-1:0]    WA,
    input  logic [WIDTH-1:0] WD,
    input  logic [AW-1:0]    RA0,
    output logic [WIDTH-1:0] RD0,
    input  logic [AW-1:0]    RA1,
    output logic [WIDTH-1:0] RD1
);

    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr_ok;
    logic [AW-1:0]    w_ra [2];
    logic [WIDTH-1:0] w_rd [2];

    // Gated by RST_N so a write held during reset is never forwarded.
    assign w_wr_ok = WE && RST_N
                  && ({1'b0, WA} < LP_DEPTH)
                  && !(ZERO_REG != 0 && WA == '0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[WA] <= WD;
        end
    end

    assign w_ra[0] = RA0;
    assign w_ra[1] = RA1;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rd[p] = '0;
            if (({1'b0, w_ra[p]} < LP_DEPTH)
                && !(ZERO_REG != 0 && w_ra[p] == '0)) begin
                w_rd[p] = r_mem[w_ra[p]];
            end
            if (BYPASS != 0 && w_wr_ok && WA == w_ra[p]) begin
                w_rd[p] = WD;
            end
        end
    end

    if (READ_REG != 0) begin : g_rreg
        logic [WIDTH-1:0] r_rd0;
        logic [WIDTH-1:0] r_rd1;

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                r_rd0 <= '0;
                r_rd1 <= '0;
            end else begin
                r_rd0 <= w_rd[0];
                r_rd1 <= w_rd[1];
            end
        end

        assign RD0 = r_rd0;
        assign RD1 = r_rd1;
    end else begin : g_comb
        assign RD0 = w_rd[0];
        assign RD1 = w_rd[1];
    end

endmodule
